// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Widths come from the global ADDR_WIDTH/INST_WIDTH defines.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

package ifu_pkg;

  localparam int ADDR_WIDTH = `ADDR_WIDTH;
  localparam int INST_WIDTH = `INST_WIDTH;

  localparam logic [INST_WIDTH-1:0] INST_NOP =
    INST_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } ifu_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
    logic                  err;
    logic                  filled;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_queue.sv
// Fetch queue: circular buffer with separate alloc, fill and free pointers.
// Pointers carry one wrap bit so full/empty and pending counts fall out.
module ifu_queue
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int IW = $clog2(DEPTH),
  localparam int PW = IW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  alloc,
  input  logic [ADDR_WIDTH-1:0] alloc_pc,
  input  logic                  fill,
  input  logic [INST_WIDTH-1:0] fill_inst,
  input  logic                  fill_err,
  input  logic                  free,
  output logic [PW-1:0]         count,
  output logic [PW-1:0]         pend,
  output ifu_entry_t            head
);

  ifu_entry_t mem [DEPTH];

  logic [PW-1:0] head_q;
  logic [PW-1:0] fill_q;
  logic [PW-1:0] tail_q;

  logic [IW-1:0] head_idx;
  logic [IW-1:0] fill_idx;
  logic [IW-1:0] tail_idx;

  assign head_idx = head_q[IW-1:0];
  assign fill_idx = fill_q[IW-1:0];
  assign tail_idx = tail_q[IW-1:0];

  assign count = tail_q - head_q;
  assign pend  = tail_q - fill_q;
  assign head  = mem[head_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
    end else begin
      // alloc never targets the fill slot: it is gated on count < DEPTH
      if (alloc) begin
        mem[tail_idx] <= '{
          pc:     alloc_pc,
          inst:   '0,
          err:    1'b0,
          filled: 1'b0
        };
        tail_q <= tail_q + PW'(1);
      end
      if (fill) begin
        mem[fill_idx].inst   <= fill_inst;
        mem[fill_idx].err    <= fill_err;
        mem[fill_idx].filled <= 1'b1;
        fill_q <= fill_q + PW'(1);
      end
      if (free) begin
        head_q <= head_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC, request issue, redirect flush and
// discard of in-flight responses; buffering lives in ifu_queue.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000,
  parameter int DEPTH = 2
) (
  input  logic                  i_ifu_clk,
  input  logic                  i_ifu_rst_n,
  output logic                  o_ifu_req_valid,
  input  logic                  i_ifu_req_ready,
  output logic [ADDR_WIDTH-1:0] o_ifu_req_addr,
  input  logic                  i_ifu_rsp_valid,
  input  logic [INST_WIDTH-1:0] i_ifu_rsp_inst,
  input  logic                  i_ifu_rsp_err,
  output logic                  o_ifu_valid,
  input  logic                  i_ifu_ready,
  output logic [INST_WIDTH-1:0] o_ifu_inst,
  output logic [INST_WIDTH-26:0] o_ifu_opcode,
  output logic [ADDR_WIDTH-1:0] o_ifu_pc,
  output logic                  o_ifu_err,
  input  logic                  i_ifu_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] i_ifu_redirect_pc
);

  localparam int PW = $clog2(DEPTH) + 1;

  ifu_state_e state_q;
  ifu_state_e state_d;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [PW-1:0]         drop_q;
  logic [PW-1:0]         drop_d;
  logic [PW-1:0]         count;
  logic [PW-1:0]         pend;

  ifu_entry_t head;

  logic req_hs;
  logic out_hs;
  logic fill;
  logic [INST_WIDTH-1:0] fill_inst;

  assign o_ifu_req_valid = (state_q == RUN) && (count < PW'(DEPTH));
  assign o_ifu_req_addr  = pc_q;
  assign req_hs = o_ifu_req_valid && i_ifu_req_ready;

  assign o_ifu_valid  = (count != '0) && head.filled;
  assign o_ifu_inst   = head.inst;
  assign o_ifu_opcode = head.inst[INST_WIDTH-26:0];
  assign o_ifu_pc     = head.pc;
  assign o_ifu_err    = head.err;
  assign out_hs = o_ifu_valid && i_ifu_ready;

  // Responses seen outside RUN belong to flushed requests
  assign fill = i_ifu_rsp_valid && (state_q == RUN);
  assign fill_inst = i_ifu_rsp_err ? INST_NOP : i_ifu_rsp_inst;

  ifu_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (i_ifu_clk),
    .rst_n     (i_ifu_rst_n),
    .flush     (i_ifu_redirect_valid),
    .alloc     (req_hs),
    .alloc_pc  (pc_q),
    .fill      (fill),
    .fill_inst (fill_inst),
    .fill_err  (i_ifu_rsp_err),
    .free      (out_hs),
    .count     (count),
    .pend      (pend),
    .head      (head)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (req_hs) begin
      pc_d = pc_q + ADDR_WIDTH'(4);
    end
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: state_d = RUN;
      FLUSH: begin
        if (i_ifu_rsp_valid) begin
          drop_d = drop_q - PW'(1);
        end
        if (drop_d == '0) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    // pend and drop_q are never both nonzero, so their sum is all in flight
    if (i_ifu_redirect_valid) begin
      pc_d   = i_ifu_redirect_pc & ~ADDR_WIDTH'(3);
      drop_d = pend + drop_q + PW'(req_hs)
             - PW'(i_ifu_rsp_valid);
      state_d = (drop_d != '0) ? FLUSH : RUN;
    end
  end

  always_ff @(posedge i_ifu_clk or negedge i_ifu_rst_n) begin
    if (!i_ifu_rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

`ifndef SYNTHESIS
  rsp_has_req: assert property (
    @(posedge i_ifu_clk) disable iff (!i_ifu_rst_n)
    i_ifu_rsp_valid |-> (pend != '0 || drop_q != '0)
  ) else $error("ifu: response with no outstanding request");
`endif

endmodule

// File: tb/tb_ifu.sv
// Scoreboard bench for ifu: in-order memory model with variable latency,
// expected deliveries queued at request time and checked by a monitor.
module tb_ifu;
  import ifu_pkg::*;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        o_ifu_req_valid;
  logic        i_ifu_req_ready;
  logic [31:0] o_ifu_req_addr;
  logic        i_ifu_rsp_valid;
  logic [31:0] i_ifu_rsp_inst;
  logic        i_ifu_rsp_err;
  logic        o_ifu_valid;
  logic        i_ifu_ready;
  logic [31:0] o_ifu_inst;
  logic [6:0]  o_ifu_opcode;
  logic [31:0] o_ifu_pc;
  logic        o_ifu_err;
  logic        i_ifu_redirect_valid;
  logic [31:0] i_ifu_redirect_pc;

  always #5 clk = ~clk;

  ifu #(
    .RESET_PC(RPC),
    .DEPTH(2)
  ) dut (
    .i_ifu_clk            (clk),
    .i_ifu_rst_n          (rst_n),
    .o_ifu_req_valid      (o_ifu_req_valid),
    .i_ifu_req_ready      (i_ifu_req_ready),
    .o_ifu_req_addr       (o_ifu_req_addr),
    .i_ifu_rsp_valid      (i_ifu_rsp_valid),
    .i_ifu_rsp_inst       (i_ifu_rsp_inst),
    .i_ifu_rsp_err        (i_ifu_rsp_err),
    .o_ifu_valid          (o_ifu_valid),
    .i_ifu_ready          (i_ifu_ready),
    .o_ifu_inst           (o_ifu_inst),
    .o_ifu_opcode         (o_ifu_opcode),
    .o_ifu_pc             (o_ifu_pc),
    .o_ifu_err            (o_ifu_err),
    .i_ifu_redirect_valid (i_ifu_redirect_valid),
    .i_ifu_redirect_pc    (i_ifu_redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  mreq_t mq[$];
  exp_t  exq[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  int nreq = 0;
  int tb_drop = 0;
  int drop_at_rdr = 0;

  logic [31:0] err_addr = 32'h8000_0008;
  logic [31:0] exp_addr = RPC;
  logic [31:0] req_addr_s = '0;
  logic [31:0] last_req = '0;
  logic [31:0] first_req = '0;
  logic [31:0] first_pc = '0;
  bit req_hs_s = 0;
  bit presented = 0;
  bit want_req = 0;
  bit want_pc = 0;
  bit saw_wrap = 0;
  bit saw_err = 0;

  function automatic logic [31:0] mem_inst(input logic [31:0] a);
    return {a[31:7] ^ 25'h0A5_5A5A, a[6:0] ^ 7'h33};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Memory: accepts sampled handshakes, answers in order after lat cycles
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst_n) begin
      mq.delete();
      presented = 0;
      i_ifu_rsp_valid = 0;
      i_ifu_rsp_inst = '0;
      i_ifu_rsp_err = 0;
    end else begin
      if (presented) void'(mq.pop_front());
      presented = 0;
      if (req_hs_s) mq.push_back('{addr: req_addr_s, due: cyc + lat - 1});
      i_ifu_rsp_valid = 0;
      i_ifu_rsp_inst = '0;
      i_ifu_rsp_err = 0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        presented = 1;
        i_ifu_rsp_valid = 1;
        i_ifu_rsp_inst = mem_inst(mq[0].addr);
        i_ifu_rsp_err = (mq[0].addr == err_addr);
      end
    end
  end

  // Monitor: samples mid-cycle, checks deliveries and request addresses
  always @(negedge clk) begin
    bit rdr;
    bit rsp;
    bit ohs;
    exp_t e;
    if (!rst_n) begin
      exq.delete();
      exp_addr = RPC;
      tb_drop = 0;
      req_hs_s = 0;
    end else begin
      req_hs_s = o_ifu_req_valid && i_ifu_req_ready;
      req_addr_s = o_ifu_req_addr;
      rdr = i_ifu_redirect_valid;
      rsp = i_ifu_rsp_valid;
      ohs = o_ifu_valid && i_ifu_ready;
      if (tb_drop > 0) chk("flush_no_req", o_ifu_req_valid, 0);
      if (ohs) begin
        if (exq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL deliver_unexpected pc=%h required=none", o_ifu_pc);
        end else begin
          e = exq.pop_front();
          chk("out_pc", o_ifu_pc, e.pc);
          chk("out_inst", o_ifu_inst, e.inst);
          chk("out_opcode", o_ifu_opcode, e.inst[6:0]);
          chk("out_err", o_ifu_err, e.err);
          if (e.err) saw_err = 1;
          if (want_pc) begin
            first_pc = o_ifu_pc;
            want_pc = 0;
          end
        end
      end
      if (req_hs_s) begin
        chk("req_addr", o_ifu_req_addr, exp_addr);
        if (last_req == 32'hFFFF_FFFC && o_ifu_req_addr == 32'h0)
          saw_wrap = 1;
        last_req = o_ifu_req_addr;
        nreq++;
        if (want_req) begin
          first_req = o_ifu_req_addr;
          want_req = 0;
        end
        if (!rdr) begin
          exq.push_back('{
            pc: exp_addr,
            inst: (exp_addr == err_addr) ? 32'h0000_0013 : mem_inst(exp_addr),
            err: (exp_addr == err_addr)
          });
        end
        exp_addr += 32'd4;
      end
      if (rsp && tb_drop > 0) tb_drop--;
      if (rdr) begin
        tb_drop = mq.size() + (req_hs_s ? 1 : 0) - (rsp ? 1 : 0);
        drop_at_rdr = tb_drop;
        exq.delete();
        exp_addr = i_ifu_redirect_pc & ~32'd3;
        want_req = 1;
        want_pc = 1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] a);
    i_ifu_redirect_valid = 1;
    i_ifu_redirect_pc = a;
    step(1);
    i_ifu_redirect_valid = 0;
  endtask

  task automatic sync_req(input string name);
    int i;
    i = 0;
    while (!o_ifu_req_valid && i < 50) begin
      step(1);
      i++;
    end
    if (!o_ifu_req_valid) begin
      checks++;
      failures++;
      $display("FAIL %s timeout req_valid=0 required=1", name);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_valid"}, o_ifu_req_valid, 0);
    chk({tag, "_req_addr"}, o_ifu_req_addr, RPC);
    chk({tag, "_valid"}, o_ifu_valid, 0);
    chk({tag, "_inst"}, o_ifu_inst, 0);
    chk({tag, "_pc"}, o_ifu_pc, 0);
    chk({tag, "_err"}, o_ifu_err, 0);
  endtask

  initial begin
    int base;
    int i;
    i_ifu_req_ready = 1;
    i_ifu_ready = 1;
    i_ifu_redirect_valid = 0;
    i_ifu_redirect_pc = '0;
    i_ifu_rsp_valid = 0;
    i_ifu_rsp_inst = '0;
    i_ifu_rsp_err = 0;
    rst_n = 0;
    step(2);
    chk_reset("rst");

    rst_n = 1;
    chk("boot_no_req", o_ifu_req_valid, 0);
    step(1);
    chk("first_req_valid", o_ifu_req_valid, 1);
    chk("first_req_addr", o_ifu_req_addr, RPC);
    step(14);

    // decode stalls; a fresh stream must stop after DEPTH requests
    i_ifu_ready = 0;
    redirect(32'h8000_0200);
    base = nreq;
    step(8);
    chk("stall_reqs", nreq - base, 2);
    chk("stall_req_valid", o_ifu_req_valid, 0);
    chk("stall_valid", o_ifu_valid, 1);
    chk("stall_pc", o_ifu_pc, 32'h8000_0200);
    i_ifu_ready = 1;
    step(4);

    // two requests in flight at latency 3, then an unaligned redirect
    lat = 3;
    redirect(32'h8000_0600);
    sync_req("sync_lat3");
    step(2);
    redirect(32'h8000_0102);
    chk("drop_count", drop_at_rdr, 2);
    step(20);
    chk("redir_first_req", first_req, 32'h8000_0100);
    chk("redir_first_pc", first_pc, 32'h8000_0100);

    lat = 1;
    redirect(32'hFFFF_FFFE);
    step(8);
    chk("wrap_first_req", first_req, 32'hFFFF_FFFC);
    chk("wrap_to_zero", saw_wrap, 1);

    // reset lands while responses are still being dropped
    lat = 3;
    redirect(32'h8000_0300);
    sync_req("sync_flush");
    step(2);
    redirect(32'h8000_0400);
    chk("flush_req_valid", o_ifu_req_valid, 0);
    rst_n = 0;
    lat = 1;
    #1;
    chk_reset("midrst");
    step(2);
    rst_n = 1;
    step(1);
    chk("restart_req_valid", o_ifu_req_valid, 1);
    chk("restart_req_addr", o_ifu_req_addr, RPC);
    step(10);

    i_ifu_req_ready = 0;
    i = 0;
    while ((mq.size() > 0 || exq.size() > 0) && i < 100) begin
      step(1);
      i++;
    end
    chk("drain_empty", exq.size(), 0);
    chk("saw_err_fetch", saw_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout reached=1 required=0");
    $fatal(1, "watchdog");
  end

endmodule
